// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: memory opcodes, byte-enable patterns and M-stage FSM states.
package mips_pkg;

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_LO   = 4'b0011;
  localparam logic [3:0] BE_HI   = 4'b1100;
  localparam logic [3:0] BE_ALL  = 4'b1111;

  typedef enum logic [1:0] {
    MA_IDLE,
    MA_WAIT,
    MA_DONE
  } ma_state_e;

  function automatic logic op_is_load(input logic [5:0] op);
    return (op == OP_LB) || (op == OP_LH) || (op == OP_LW) ||
           (op == OP_LBU) || (op == OP_LHU);
  endfunction

  function automatic logic op_is_store(input logic [5:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/m_load_ext.sv
// Load result extraction: picks the byte/half lane from the read word and sign- or zero-extends it.
module m_load_ext
  import mips_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  a_i,
  input  logic [5:0]  op_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (a_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = a_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    ld_data_o = word_i;
    case (op_i)
      OP_LB:   ld_data_o = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  ld_data_o = {24'h0, byte_sel};
      OP_LH:   ld_data_o = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  ld_data_o = {16'h0, half_sel};
      default: ld_data_o = word_i;
    endcase
  end

endmodule

// File: rtl/m_mem_access.sv
// M-stage data-memory controller: req/ack handshake, pipeline stall, load extension, timeout.
// Optional macro ALIGN_CHECK_EN: misaligned lw/sw/lh/lhu/sh raise mem_err instead of issuing.
module m_mem_access
  import mips_pkg::*;
#(
  parameter int unsigned ACK_TIMEOUT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m_instr,
  input  logic [31:0] m_pc,
  input  logic [31:0] m_rt_data,
  input  logic [31:0] m_alu,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        stall,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        mem_err,
  output logic [31:0] ex_pc
);

  ma_state_e   state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q;
  logic        cap_en;
  logic        req_c, stall_c;
  logic        misalign, timeout;
  logic [31:0] wdata_c, ext_data;
  logic [3:0]  be_c;

  logic [5:0] op;
  logic [1:0] a;
  logic       is_ld, is_st, is_mem;

  assign op     = m_instr[31:26];
  assign a      = m_alu[1:0];
  assign is_ld  = op_is_load(op);
  assign is_st  = op_is_store(op);
  assign is_mem = is_ld | is_st;

`ifdef ALIGN_CHECK_EN
  assign misalign = (((op == OP_LW) || (op == OP_SW)) && (a != 2'b00)) ||
                    (((op == OP_LH) || (op == OP_LHU) || (op == OP_SH)) && a[0]);
`else
  assign misalign = 1'b0;
`endif

  assign timeout = (ACK_TIMEOUT != 0) && (cnt_q == ACK_TIMEOUT - 1);

  always_comb begin
    wdata_c = '0;
    be_c    = BE_NONE;
    case (op)
      OP_SB: begin
        wdata_c = {4{m_rt_data[7:0]}};
        be_c    = 4'b0001 << a;
      end
      OP_SH: begin
        wdata_c = {2{m_rt_data[15:0]}};
        be_c    = a[1] ? BE_HI : BE_LO;
      end
      OP_SW: begin
        wdata_c = m_rt_data;
        be_c    = BE_ALL;
      end
      default: ;
    endcase
  end

  // err_q only lives for the DONE cycle that follows the failing transition.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    cap_en  = 1'b0;
    req_c   = 1'b0;
    stall_c = 1'b0;
    case (state_q)
      MA_IDLE: begin
        cnt_d = '0;
        if (is_mem) begin
          stall_c = 1'b1;
          if (misalign) begin
            err_d   = 1'b1;
            state_d = MA_DONE;
          end else begin
            req_c = 1'b1;
            if (mem_ack) begin
              cap_en  = 1'b1;
              state_d = MA_DONE;
            end else begin
              state_d = MA_WAIT;
            end
          end
        end
      end
      MA_WAIT: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (mem_ack) begin
          cap_en  = 1'b1;
          state_d = MA_DONE;
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = MA_DONE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end
      MA_DONE: state_d = MA_IDLE;
      default: state_d = MA_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= MA_IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      if (cap_en) rdata_q <= mem_rdata;
    end
  end

  m_load_ext u_load_ext (
    .word_i    (rdata_q),
    .a_i       (a),
    .op_i      (op),
    .ld_data_o (ext_data)
  );

  assign mem_req   = !reset && req_c;
  assign mem_we    = mem_req && is_st;
  assign mem_addr  = mem_req ? {m_alu[31:2], 2'b00} : '0;
  assign mem_wdata = mem_req ? wdata_c : '0;
  assign mem_be    = mem_req ? be_c : BE_NONE;
  assign stall     = !reset && stall_c;
  assign ld_valid  = !reset && (state_q == MA_DONE) && is_ld && !err_q;
  assign ld_data   = ld_valid ? ext_data : '0;
  assign mem_err   = !reset && (state_q == MA_DONE) && err_q;
  assign ex_pc     = mem_err ? m_pc : '0;

endmodule
